// File: rtl/sprite_pkg.sv
// Shared types and constants for the sprite position controller.
// SPRITE_POS_WRAP_EN selects wrap-around instead of saturation at the screen edges.
package sprite_pkg;

  localparam int H_ACTIVE = 640;
  localparam int V_ACTIVE = 480;
  localparam int SPRITE_W = 5;
  localparam int SPRITE_H = 5;
  localparam int POS_W    = 10;

  typedef enum logic [1:0] {
    DIR_PY = 2'b00,
    DIR_NY = 2'b01,
    DIR_PX = 2'b10,
    DIR_NX = 2'b11
  } dir_e;

  typedef enum logic {
    S_ARB  = 1'b0,
    S_HOLD = 1'b1
  } state_e;

  // One axis step in 11 bits; bit 10 of the difference flags an underflow.
  function automatic logic [POS_W-1:0] step_axis(
    input logic [POS_W-1:0] cur,
    input logic             inc,
    input logic [10:0]      step,
    input logic [10:0]      max_v
  );
    logic [10:0] res;
    if (inc) begin
      res = {1'b0, cur} + step;
      if (res > max_v) begin
`ifdef SPRITE_POS_WRAP_EN
        res = 11'd0;
`else
        res = max_v;
`endif
      end
    end else begin
      res = {1'b0, cur} - step;
      if (res[10]) begin
`ifdef SPRITE_POS_WRAP_EN
        res = max_v;
`else
        res = 11'd0;
`endif
      end
    end
    return res[POS_W-1:0];
  endfunction

endpackage

// File: rtl/sprite_pos_ctrl_if.sv
// Move-request handshake bundle shared by the two requesters and the controller.
// Used identically whether or not SPRITE_POS_WRAP_EN is defined.
interface sprite_pos_ctrl_if;
  logic [1:0] req_valid;
  logic [1:0] req_dir0;
  logic [1:0] req_dir1;
  logic [1:0] req_ready;

  modport master (output req_valid, output req_dir0, output req_dir1, input req_ready);
  modport slave  (input req_valid, input req_dir0, input req_dir1, output req_ready);
endinterface

// File: rtl/sprite_pos_ctrl_rr_arb2.sv
// Two-way round-robin arbiter; the pointer moves only when a grant is accepted.
// Independent of SPRITE_POS_WRAP_EN.
module rr_arb2 (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_en,
  input  logic [1:0] i_req,
  output logic [1:0] o_gnt,
  output logic       o_accept
);

  logic ptr_q, ptr_d;  // 1 = requester 1 has priority on a tie

  always_comb begin
    o_gnt = 2'b00;
    if (i_en) begin
      case (i_req)
        2'b01:   o_gnt = 2'b01;
        2'b10:   o_gnt = 2'b10;
        2'b11:   o_gnt = ptr_q ? 2'b10 : 2'b01;
        default: o_gnt = 2'b00;
      endcase
    end
    o_accept = |(o_gnt & i_req);
    ptr_d    = ptr_q;
    if (o_accept) ptr_d = o_gnt[0];
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) ptr_q <= 1'b0;
    else          ptr_q <= ptr_d;
  end

endmodule

// File: rtl/sprite_pos_ctrl.sv
// Sprite position controller: one arbitrated move per frame into a shadow position,
// committed on each VSYNC falling edge. SPRITE_POS_WRAP_EN enables edge wrap-around.
module sprite_pos_ctrl
  import sprite_pkg::*;
#(
  parameter int P_X_MAX  = H_ACTIVE - SPRITE_W,
  parameter int P_Y_MAX  = V_ACTIVE - SPRITE_H,
  parameter int P_STEP   = 1,
  parameter int P_X_INIT = 0,
  parameter int P_Y_INIT = 0
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 i_vs,
  sprite_pos_ctrl_if.slave     req_if,
  output logic [POS_W-1:0]     o_x_pos,
  output logic [POS_W-1:0]     o_y_pos,
  output logic                 o_frame_tick
);

  localparam logic [10:0]      X_MAX  = 11'(P_X_MAX);
  localparam logic [10:0]      Y_MAX  = 11'(P_Y_MAX);
  localparam logic [10:0]      STEP   = 11'(P_STEP);
  localparam logic [POS_W-1:0] X_INIT = POS_W'(P_X_INIT);
  localparam logic [POS_W-1:0] Y_INIT = POS_W'(P_Y_INIT);

  logic             vs_meta_q, vs_sync_q, vs_prev_q, tick_q;
  state_e           state_q;
  logic [POS_W-1:0] shadow_x_q, shadow_y_q, shadow_x_d, shadow_y_d;
  logic [POS_W-1:0] pos_x_q, pos_y_q;
  logic [1:0]       gnt;
  logic             accept, arb_en;
  dir_e             sel_dir;

  // i_vs is asynchronous: two flops for metastability, a third for edge detection.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      vs_meta_q <= 1'b1;
      vs_sync_q <= 1'b1;
      vs_prev_q <= 1'b1;
      tick_q    <= 1'b0;
    end else begin
      vs_meta_q <= i_vs;
      vs_sync_q <= vs_meta_q;
      vs_prev_q <= vs_sync_q;
      tick_q    <= vs_prev_q & ~vs_sync_q;
    end
  end

  // The frame tick always wins, so a request in that cycle stays pending.
  assign arb_en = i_rst_n & (state_q == S_ARB) & ~tick_q;

  rr_arb2 u_arb (
    .i_clk    (i_clk),
    .i_rst_n  (i_rst_n),
    .i_en     (arb_en),
    .i_req    (req_if.req_valid),
    .o_gnt    (gnt),
    .o_accept (accept)
  );

  assign req_if.req_ready = gnt;
  assign sel_dir          = dir_e'(gnt[1] ? req_if.req_dir1 : req_if.req_dir0);

  always_comb begin
    shadow_x_d = shadow_x_q;
    shadow_y_d = shadow_y_q;
    if (accept) begin
      case (sel_dir)
        DIR_PY:  shadow_y_d = step_axis(shadow_y_q, 1'b1, STEP, Y_MAX);
        DIR_NY:  shadow_y_d = step_axis(shadow_y_q, 1'b0, STEP, Y_MAX);
        DIR_PX:  shadow_x_d = step_axis(shadow_x_q, 1'b1, STEP, X_MAX);
        default: shadow_x_d = step_axis(shadow_x_q, 1'b0, STEP, X_MAX);
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q    <= S_ARB;
      shadow_x_q <= X_INIT;
      shadow_y_q <= Y_INIT;
      pos_x_q    <= X_INIT;
      pos_y_q    <= Y_INIT;
    end else begin
      shadow_x_q <= shadow_x_d;
      shadow_y_q <= shadow_y_d;
      case (state_q)
        S_ARB: begin
          if (tick_q) begin
            pos_x_q <= shadow_x_q;
            pos_y_q <= shadow_y_q;
          end else if (accept) begin
            state_q <= S_HOLD;
          end
        end
        default: begin
          if (tick_q) begin
            pos_x_q <= shadow_x_q;
            pos_y_q <= shadow_y_q;
            state_q <= S_ARB;
          end
        end
      endcase
    end
  end

  assign o_x_pos      = pos_x_q;
  assign o_y_pos      = pos_y_q;
  assign o_frame_tick = tick_q;

endmodule
